// File: rtl/uart_tx_block.sv
// uart_tx_block: UART serial transmitter (start, 8 data bits LSB first,
// optional even parity, 1 stop bit) with a programmable bit period.
// Optional feature macro: UART_TX_PARITY_EN adds the even-parity bit.
module uart_tx_block #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tx_start,
   input  logic [7:0]              tx_data,
   input  logic [NUM_CNT_BITS-1:0] bit_period,
   output logic                    serial_out,
   output logic                    tx_busy,
   output logic                    tx_done
);

   localparam int unsigned CNT_W  = NUM_CNT_BITS;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0]    period_q, period_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                serial_q, serial_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                bit_end;
   logic [CNT_W-1:0]    timer_run;
`ifdef UART_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif

   // State and datapath registers; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         period_q  <= CNT_W'(1);
         bit_idx_q <= '0;
         shift_q   <= '0;
         serial_q  <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         period_q  <= period_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         serial_q  <= serial_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Next-state, bit timer and registered-output decode.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      period_d  = period_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      // The timer runs 1..period_q and restarts at 1 when a bit ends.
      bit_end   = (timer_q == period_q);
      timer_run = bit_end ? CNT_W'(1) : timer_q + CNT_W'(1);

      unique case (state_q)
         IDLE: begin
            if (tx_start) begin
               state_d   = START;
               shift_d   = tx_data;
               period_d  = (bit_period == '0) ? CNT_W'(1) : bit_period;
               timer_d   = CNT_W'(1);
               bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^tx_data;
`endif
            end
         end
         START: begin
            timer_d = timer_run;
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            timer_d = timer_run;
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[DATA_W-1:1]};
               bit_idx_d = bit_idx_q + IDX_W'(1);
               if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            timer_d = timer_run;
            if (bit_end) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            timer_d = timer_run;
            if (bit_end) begin
               state_d = IDLE;
               timer_d = '0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase

      // Line level follows the state being entered so it is valid right after the edge.
      unique case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  serial_d = parity_d;
`endif
         default: serial_d = 1'b1;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign serial_out = serial_q;
   assign tx_busy    = busy_q;
   assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// tb_uart_tx_block: directed bench with a frame-level reference model.
module tb_uart_tx_block;

   localparam int unsigned CNT = 4;

   logic           clk;
   logic           rst;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic [CNT-1:0] bit_period;
   logic           serial_out;
   logic           tx_busy;
   logic           tx_done;

   int n_chk  = 0;
   int n_pass = 0;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   uart_tx_block #(.NUM_CNT_BITS(CNT)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .bit_period (bit_period),
      .serial_out (serial_out),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Frame model: on acceptance, build the bit list; line shows bits[j/P] for j < NBITS*P.
   bit m_started = 0;
   bit m_active  = 0;
   bit m_done    = 0;
   int m_j       = 0;
   int m_p       = 1;
   int m_len     = 0;
   bit m_bits[NBITS];

   always @(posedge clk) begin
      m_started = 1;
      if (rst) begin
         m_active = 0;
         m_done   = 0;
      end else if (m_active) begin
         m_j++;
         m_done = 0;
         if (m_j == m_len) begin
            m_active = 0;
            m_done   = 1;
         end
      end else begin
         m_done = 0;
         if (tx_start) begin
            m_p = (bit_period == 0) ? 1 : int'(bit_period);
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[i+1] = tx_data[i];
`ifdef UART_TX_PARITY_EN
            m_bits[9] = ^tx_data;
`endif
            m_bits[NBITS-1] = 1'b1;
            m_len    = NBITS * m_p;
            m_j      = 0;
            m_active = 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (m_started) begin
         chk("model_serial", int'(serial_out), m_active ? int'(m_bits[m_j / m_p]) : 1);
         chk("model_busy",   int'(tx_busy),    int'(m_active));
         chk("model_done",   int'(tx_done),    int'(m_done));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic skip(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start_frame(input logic [7:0] d, input int p);
      tx_data    = d;
      bit_period = CNT'(p);
      tx_start   = 1'b1;
      tick();
      tx_start   = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (tx_done !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
   endtask

   task automatic frame_len(input string name, input logic [7:0] d, input int p, input int exp);
      int n;
      start_frame(d, p);
      wait_done(n);
      chk(name, n, exp);
      tick();
   endtask

   int lit_a5[NBITS];
   int n;

   initial begin
`ifdef UART_TX_PARITY_EN
      lit_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
      lit_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
      rst        = 1'b1;
      tx_start   = 1'b1;
      tx_data    = 8'hFF;
      bit_period = CNT'(1);

      // Reset wins over a simultaneous start request.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_serial", int'(serial_out), 1);
         chk("rst_busy",   int'(tx_busy),    0);
         chk("rst_done",   int'(tx_done),    0);
      end
      rst      = 1'b0;
      tx_start = 1'b0;
      skip(2);
      chk("idle_busy", int'(tx_busy), 0);

      // 0xA5 at P=4 against a hand-written waveform.
      start_frame(8'hA5, 4);
      for (int j = 0; j < NBITS * 4; j++) begin
         if (j % 4 == 0) chk($sformatf("a5_bit%0d", j / 4), int'(serial_out), lit_a5[j / 4]);
         if (j == 0 || j == NBITS * 4 - 1) chk("a5_busy", int'(tx_busy), 1);
         tick();
      end
      chk("a5_done",    int'(tx_done),    1);
      chk("a5_busy_lo", int'(tx_busy),    0);
      chk("a5_idle",    int'(serial_out), 1);
      tick();
      chk("a5_done_1cyc", int'(tx_done), 0);

      // Bit period edge cases.
      frame_len("len_p0",  8'h00, 0,  NBITS);
      frame_len("len_p1",  8'h00, 1,  NBITS);
      frame_len("len_p15", 8'h5A, 15, NBITS * 15);

      // Back-to-back with tx_start held and data changed mid-frame.
      tx_data    = 8'h3C;
      bit_period = CNT'(2);
      tx_start   = 1'b1;
      tick();
      skip(6);
      chk("b2b_3c_bit3", int'(serial_out), 1);
      tx_data = 8'hFF;
      wait_done(n);
      chk("b2b_len1", n, NBITS * 2 - 6);
      tick();
      chk("b2b_restart_busy", int'(tx_busy),    1);
      chk("b2b_restart_line", int'(serial_out), 0);
      skip(2);
      chk("b2b_ff_bit1", int'(serial_out), 1);
      tx_start = 1'b0;
      wait_done(n);
      chk("b2b_len2", n, NBITS * 2 - 2);
      skip(3);
      chk("b2b_no_queue", int'(tx_busy), 0);

      // Reset in the middle of the data bits.
      start_frame(8'h55, 3);
      skip(9);
      chk("mid_busy_pre", int'(tx_busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_serial", int'(serial_out), 1);
      chk("mid_busy",   int'(tx_busy),    0);
      chk("mid_done",   int'(tx_done),    0);
      skip(3);
      frame_len("mid_refr", 8'h55, 3, NBITS * 3);

`ifdef UART_TX_PARITY_EN
      // Parity bit occupies frame bit 9.
      start_frame(8'h07, 2);
      skip(18);
      chk("par07_a", int'(serial_out), 1);
      tick();
      chk("par07_b", int'(serial_out), 1);
      wait_done(n);
      chk("par07_len", n + 19, 22);
      tick();
      start_frame(8'h03, 2);
      skip(18);
      chk("par03_a", int'(serial_out), 0);
      tick();
      chk("par03_b", int'(serial_out), 0);
      wait_done(n);
      tick();
`endif

      skip(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_block.md
# uart_tx_block

Serial transmitter for the UART link: takes a parallel byte and drives a framed asynchronous serial line (start bit, 8 data bits LSB first, optional parity, 1 stop bit). Each bit lasts a programmable number of clock cycles. It is the transmit counterpart of the lab receiver path and uses the same flex-counter style bit timer. It sits between the byte-producing logic and the serial pad.

## Interface
Parameters:
- NUM_CNT_BITS, 4: width of the bit-period value and the internal bit timer.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_start  input  1  request to send `tx_data`. Sampled only in IDLE.
- tx_data  input  8  byte to send. Captured on acceptance.
- bit_period  input  NUM_CNT_BITS  clock cycles per serial bit. Captured on acceptance; 0 is treated as 1.
- serial_out  output  1  serial line, registered. Idles high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when a frame finishes.

## Operation
- Reset values: serial_out=1, tx_busy=0, tx_done=0, state IDLE, timer=0, bit index=0.
- FSM states: IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP.
  - IDLE to START: on a clock edge where tx_start=1. At that edge, tx_data goes into the shift register and bit_period goes into period_q (0 becomes 1).
  - START to DATA: after period_q cycles.
  - DATA: sends shift_reg[0], then shifts right. After 8 bits, moves to PARITY, or to STOP if parity is not compiled in.
  - PARITY to STOP: after period_q cycles.
  - STOP to IDLE: after period_q cycles.
- Bit timer: counts 1..period_q. Reaching period_q ends the current bit and restarts the count at 1. Timer width is NUM_CNT_BITS; it never wraps past period_q.
- serial_out by state: 0 in START, the data bit in DATA, 1 in STOP and IDLE.
- tx_busy is 1 in every state except IDLE.
- Changes to tx_data or bit_period during a frame are ignored.
- tx_start while busy is ignored. It is not queued.
- rst=1 in any state aborts the frame: the next edge restores all reset values. There is no partial stop bit.
- If rst and tx_start are both high on the same edge, reset wins.

## Timing
- P is the captured bit period. L is the frame length: 10·P cycles, or 11·P with parity.
- Latency: tx_start accepted at edge k makes serial_out=0 and tx_busy=1 after edge k.
- Bit n of the frame (start is n=0) is driven after edges k+n·P through k+(n+1)·P−1.
- After edge k+L: state is IDLE, tx_busy=0, tx_done=1 for exactly one cycle, serial_out=1.
- A tx_start in the tx_done cycle is accepted at edge k+L+1. The minimum frame-to-frame spacing is therefore L+1 cycles, with 1 idle-high cycle between frames.
- With P=1, each bit lasts one cycle; the frame is 10 cycles.
- The maximum P is 2^NUM_CNT_BITS−1 (15 by default).

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is present. It sends the even-parity bit (XOR of the 8 data bits) for P cycles between the last data bit and STOP. Frame is 11·P.
- UART_TX_PARITY_EN undefined: there is no PARITY state. DATA goes straight to STOP. Frame is 10·P.

## Test plan
- Reset: hold rst=1 for 2 cycles with tx_start=1 -> serial_out=1, tx_busy=0, tx_done=0 throughout; no frame starts.
- Single frame: tx_data=0xA5, bit_period=4, tx_start pulsed at edge k, no parity -> serial_out sequence, 4 cycles per bit from edge k: 0,1,0,1,0,0,1,0,1,1. tx_done pulses exactly once after edge k+40; tx_busy is high for 40 cycles.
- Period edge cases: bit_period=0 and bit_period=1 with tx_data=0x00 -> both give a 10-cycle frame (0 ×9, then 1). bit_period=15 -> 150-cycle frame.
- Busy and back-to-back: tx_start held high continuously; tx_data=0x3C, then changed to 0xFF mid-frame -> first frame sends 0x3C. A second frame with 0xFF starts exactly 1 cycle after tx_done. Requests during busy are not queued.
- Reset mid-frame: rst asserted during the DATA state of a 0x55 frame -> serial_out=1 and tx_busy=0 after that edge; no tx_done pulse. A new tx_start afterwards sends a full frame.
- Parity (UART_TX_PARITY_EN defined): tx_data=0x07, P=2 -> parity bit=1 for 2 cycles before the stop bit; frame is 22 cycles. With tx_data=0x03 -> parity bit=0.
